multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle successor to the single-cycle control decoder. It sequences each RV32I instruction through fetch, decode, execute, memory and writeback states, and drives the same datapath control signals per state. It handshakes with a shared instruction/data memory that may take several cycles to answer. Illegal opcodes and memory timeouts raise a trap instead of decoding to all-zero controls. It sits between the instruction register / ALU flags and the datapath muxes, register file and memory port.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for mem_ack in FETCH or MEM; 0 disables the timeout.
TO_W, $clog2(MEM_TIMEOUT+1), width of the timeout counter (derived; do not override).

Ports:
clk  input  1  clock, all state changes on rising edge.
rst_n  input  1  reset; asynchronous, active-low.
opcode  input  5  instr[6:2] from instruction register; sampled only in DECODE.
branch_taken  input  1  ALU branch comparison result; valid in EXECUTE.
mem_ack  input  1  memory completes the current request this cycle.
mem_req  output  1  memory request; held high until mem_ack.
mem_we  output  1  write qualifier for mem_req (store).
ir_write  output  1  load instruction register (fetch data).
pc_write  output  1  update PC this cycle.
pc_sel  output  2  00 pc+4, 01 branch target, 10 jump target (JAL/JALR).
alu_op  output  2  00 add, 01 branch compare, 10 funct-decoded.
alu_src  output  1  0 rs2, 1 immediate.
mem_to_reg  output  1  writeback source is memory data.
reg_write  output  1  register file write enable.
trap  output  1  sticky; core halted.
trap_cause  output  2  01 illegal opcode, 10 memory timeout; 00 when trap=0.
state  output  3  current FSM state, for debug.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, TRAP=6.
- Reset (rst_n low, any time, including mid-transaction): state=IDLE, op_q=0, counter=0. All outputs 0.
- Outputs are decoded combinationally from state and the registered op_q. They do not depend on opcode outside DECODE.
- IDLE: always go to FETCH next cycle.
- FETCH:
  - mem_req=1, mem_we=0.
  - On mem_ack: ir_write=1 in that same cycle, then go to DECODE.
- DECODE: latch opcode into op_q.
  - Legal opcodes: 00000 LOAD, 00100 OP-IMM, 00101 AUIPC, 01000 STORE, 01100 OP, 01101 LUI, 11000 BRANCH, 11001 JALR, 11011 JAL. Legal goes to EXECUTE.
  - Any other opcode goes to TRAP with cause 01.
- EXECUTE, control values:
  - OP: alu_op=10, alu_src=0.
  - OP-IMM: alu_op=10, alu_src=1.
  - LOAD, STORE, AUIPC, LUI, JAL, JALR: alu_op=00, alu_src=1.
  - BRANCH: alu_op=01, alu_src=0.
- EXECUTE, next state:
  - BRANCH: pc_write=1, pc_sel=01 if branch_taken else 00, then FETCH.
  - LOAD/STORE: go to MEM.
  - Others: go to WRITEBACK.
- MEM:
  - mem_req=1, mem_we=1 for STORE only.
  - On mem_ack, LOAD goes to WRITEBACK.
  - On mem_ack, STORE asserts pc_write=1, pc_sel=00, then FETCH.
- WRITEBACK:
  - reg_write=1, pc_write=1, then FETCH.
  - mem_to_reg=1 for LOAD only.
  - pc_sel=10 for JAL/JALR, 00 otherwise.
- Timeout (MEM_TIMEOUT>0):
  - Counter clears on entry to FETCH/MEM and increments each cycle without mem_ack.
  - If the counter reaches MEM_TIMEOUT with mem_ack still low, go to TRAP with cause 10 and drop mem_req.
  - mem_ack in the same cycle as the limit wins (no trap).
- TRAP: trap=1, trap_cause held; every other output 0; remains in TRAP until reset.
- mem_ack outside FETCH/MEM is ignored.
- Latency with single-cycle ack:
  - OP / OP-IMM / LUI / AUIPC / JAL / JALR: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.

Test Plan:
- Release reset, mem_ack=1 every cycle, opcode=01100: state sequence 0,1,2,3,5,1. reg_write=1 and pc_write=1 with pc_sel=00 only in WRITEBACK. ir_write pulses once per fetch.
- LOAD (00000), mem_ack delayed 3 cycles in MEM: mem_req held 4 cycles with mem_we=0. WRITEBACK asserts mem_to_reg=1 and reg_write=1. Total 8 cycles FETCH to FETCH.
- BRANCH (11000), branch_taken=1, then again with 0: EXECUTE gives pc_write=1 with pc_sel=01, then 00. reg_write is never asserted.
- opcode=11111 in DECODE: next cycle state=6, trap=1, trap_cause=01. Outputs stay frozen for 20 cycles. rst_n low clears to IDLE.
- MEM_TIMEOUT=4, STORE with mem_ack never asserted: after 4 MEM cycles with mem_req=1, mem_we=1, the FSM enters TRAP with trap_cause=10. A second run asserting mem_ack on the 4th cycle must not trap.
- Assert rst_n low mid-MEM with mem_req=1: outputs go to 0 immediately (async), no clock edge needed. After release, the FSM restarts IDLE→FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RV32I control FSM with memory handshake, timeout and trap
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_sel,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [2:0] state
);
    localparam int CW = (TO_W > 0) ? TO_W : 1;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_OPIMM = 5'b00100;
    localparam logic [4:0] OP_AUIPC = 5'b00101;
    localparam logic [4:0] OP_STORE = 5'b01000;
    localparam logic [4:0] OP_OP    = 5'b01100;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_BR    = 5'b11000;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_JAL   = 5'b11011;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEM       = 3'd4,
        WRITEBACK = 3'd5,
        TRAP      = 3'd6
    } state_t;

    state_t        cur, nxt;
    logic [4:0]    op_q;
    logic [CW-1:0] cnt;
    logic [1:0]    cause_q;
    logic          legal, waiting, timeout, entering, is_br, is_ld, is_st, is_jmp, is_alu;

    assign legal    = opcode inside {OP_LOAD, OP_OPIMM, OP_AUIPC, OP_STORE, OP_OP,
                                     OP_LUI, OP_BR, OP_JALR, OP_JAL};
    assign is_br    = op_q == OP_BR;
    assign is_ld    = op_q == OP_LOAD;
    assign is_st    = op_q == OP_STORE;
    assign is_jmp   = op_q == OP_JAL || op_q == OP_JALR;
    assign is_alu   = op_q == OP_OP || op_q == OP_OPIMM;
    assign waiting  = (cur == FETCH || cur == MEM) && !mem_ack;
    // the limit cycle itself counts as a wait cycle, so trap fires on the MEM_TIMEOUT-th unacked cycle
    assign timeout  = MEM_TIMEOUT > 0 && waiting && cnt == CW'(MEM_TIMEOUT - 1);
    assign entering = nxt != cur && (nxt == FETCH || nxt == MEM);
    assign state    = cur;

    // state, latched opcode, wait counter and trap cause
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= IDLE;
            op_q    <= '0;
            cnt     <= '0;
            cause_q <= '0;
        end else begin
            cur     <= nxt;
            op_q    <= (cur == DECODE) ? opcode : op_q;
            cnt     <= entering ? '0 : waiting ? cnt + 1'b1 : cnt;
            cause_q <= (nxt == TRAP && cur != TRAP) ? ((cur == DECODE) ? 2'b01 : 2'b10) : cause_q;
        end
    end

    // next-state sequencing
    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:      nxt = FETCH;
            FETCH:     nxt = mem_ack ? DECODE : timeout ? TRAP : FETCH;
            DECODE:    nxt = legal ? EXECUTE : TRAP;
            EXECUTE:   nxt = is_br ? FETCH : (is_ld || is_st) ? MEM : WRITEBACK;
            MEM:       nxt = mem_ack ? (is_ld ? WRITEBACK : FETCH) : timeout ? TRAP : MEM;
            WRITEBACK: nxt = FETCH;
            TRAP:      nxt = TRAP;
            default:   nxt = IDLE;
        endcase
    end

    // datapath controls decoded from state and latched opcode
    always_comb begin
        mem_req    = cur == FETCH || cur == MEM;
        mem_we     = cur == MEM && is_st;
        ir_write   = cur == FETCH && mem_ack;
        pc_write   = (cur == EXECUTE && is_br) || (cur == MEM && mem_ack && is_st) || cur == WRITEBACK;
        pc_sel     = (cur == EXECUTE && is_br && branch_taken) ? 2'b01 :
                     (cur == WRITEBACK && is_jmp) ? 2'b10 : 2'b00;
        alu_op     = (cur != EXECUTE) ? 2'b00 : is_alu ? 2'b10 : is_br ? 2'b01 : 2'b00;
        alu_src    = cur == EXECUTE && !(op_q == OP_OP || is_br);
        mem_to_reg = cur == WRITEBACK && is_ld;
        reg_write  = cur == WRITEBACK;
        trap       = cur == TRAP;
        trap_cause = (cur == TRAP) ? cause_q : 2'b00;
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction-level check of multicycle_control
module tb_multicycle_control;
    localparam int TO = 4;

    localparam logic [4:0] LD   = 5'b00000;
    localparam logic [4:0] OPI  = 5'b00100;
    localparam logic [4:0] AUI  = 5'b00101;
    localparam logic [4:0] ST   = 5'b01000;
    localparam logic [4:0] OPR  = 5'b01100;
    localparam logic [4:0] LUI  = 5'b01101;
    localparam logic [4:0] BR   = 5'b11000;
    localparam logic [4:0] JALR = 5'b11001;
    localparam logic [4:0] JAL  = 5'b11011;

    logic       clk = 1'b0, rst_n = 1'b1, branch_taken = 1'b0, mem_ack = 1'b0;
    logic [4:0] opcode = 5'd0;
    logic       mem_req, mem_we, ir_write, pc_write, alu_src, mem_to_reg, reg_write, trap;
    logic [1:0] pc_sel, alu_op, trap_cause;
    logic [2:0] state;
    logic [16:0] obs;
    logic [4:0] legal_ops [9] = '{LD, OPI, AUI, ST, OPR, LUI, BR, JALR, JAL};
    int n_chk = 0, n_fail = 0;

    multicycle_control #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
        .pc_write(pc_write), .pc_sel(pc_sel), .alu_op(alu_op), .alu_src(alu_src),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .trap(trap),
        .trap_cause(trap_cause), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {state, trap, trap_cause, mem_req, mem_we, ir_write, pc_write,
                  pc_sel, alu_op, alu_src, mem_to_reg, reg_write};

    function automatic logic [16:0] ev(input logic [2:0] st, input logic [1:0] tc,
                                       input logic mr, mw, irw, pw, input logic [1:0] ps, ao,
                                       input logic as, m2r, rw);
        return {st, tc != 2'b00, tc, mr, mw, irw, pw, ps, ao, as, m2r, rw};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [4:0] ro();
        return 5'($urandom);
    endfunction

    function automatic bit is_legal(input logic [4:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [16:0] e, input logic ack,
                        input logic [4:0] opc, input logic bt);
        @(negedge clk);
        mem_ack = ack;
        opcode = opc;
        branch_taken = bt;
        #1 check(tag, obs, e);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1 check("async_rst", obs, 17'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_idle", obs, 17'd0);
    endtask

    task automatic trap_hold(input logic [1:0] c);
        for (int i = 0; i < 20; i++)
            step("trap", ev(3'd6, c, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0), rb(), ro(), rb());
        do_reset();
    endtask

    // memory wait of d cycles before ack; to=1 if the bound expires first
    task automatic mem_phase(input string tag, input int d, input logic [2:0] st, input logic we,
                             input logic irw, input logic pw, output bit to);
        to = 1'b0;
        for (int k = 0; k <= d; k++) begin
            if (k == d) begin
                step(tag, ev(st, 2'd0, 1'b1, we, irw, pw, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0), 1'b1, ro(), rb());
                break;
            end
            step(tag, ev(st, 2'd0, 1'b1, we, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0), 1'b0, ro(), rb());
            if (k == TO - 1) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    // one instruction from FETCH; leaves FSM about to enter FETCH, or reset to IDLE after a trap
    task automatic run_instr(input logic [4:0] op, input logic bt, input int fd, input int md);
        bit to;
        logic [1:0] ao;
        mem_phase("fetch", fd, 3'd1, 1'b0, 1'b1, 1'b0, to);
        if (to) begin trap_hold(2'b10); return; end
        step("decode", ev(3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0), rb(), op, rb());
        if (!is_legal(op)) begin trap_hold(2'b01); return; end
        ao = (op == OPR || op == OPI) ? 2'd2 : (op == BR) ? 2'd1 : 2'd0;
        step("execute", ev(3'd3, 2'd0, 1'b0, 1'b0, 1'b0, op == BR, (op == BR && bt) ? 2'd1 : 2'd0,
             ao, !(op == OPR || op == BR), 1'b0, 1'b0), rb(), ro(), bt);
        if (op == BR) return;
        if (op == LD || op == ST) begin
            mem_phase("mem", md, 3'd4, op == ST, 1'b0, op == ST, to);
            if (to) begin trap_hold(2'b10); return; end
            if (op == ST) return;
        end
        step("writeback", ev(3'd5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, (op == JAL || op == JALR) ? 2'd2 : 2'd0,
             2'd0, 1'b0, op == LD, 1'b1), rb(), ro(), rb());
    endtask

    function automatic int rdelay();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO, TO + 2)) : int'($urandom_range(0, TO - 1));
    endfunction

    initial begin
        do_reset();
        run_instr(OPR, 1'b0, 0, 0);
        run_instr(LD, 1'b0, 0, 3);
        run_instr(BR, 1'b1, 0, 0);
        run_instr(BR, 1'b0, 0, 0);
        run_instr(5'b11111, 1'b0, 0, 0);
        run_instr(ST, 1'b0, 0, 100);
        run_instr(ST, 1'b0, 0, 3);
        run_instr(LD, 1'b0, 2, 0);
        run_instr(JAL, 1'b0, 1, 0);
        begin
            bit to;
            mem_phase("fetch", 0, 3'd1, 1'b0, 1'b1, 1'b0, to);
            step("decode", ev(3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0), 1'b0, LD, 1'b0);
            step("execute", ev(3'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0), 1'b0, ro(), 1'b0);
            step("mem_pre_rst", ev(3'd4, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0), 1'b0, ro(), 1'b0);
            do_reset();
        end
        for (int i = 0; i < 300; i++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 9) == 0) ? ro() : legal_ops[$urandom_range(0, 8)];
            run_instr(op, rb(), rdelay(), rdelay());
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
